// File: rtl/display_pkg.sv
// Shared definitions for the SSD1306 panel driver: serializer command codes,
// FSM state encodings, panel geometry and the fixed command tables.
package display_pkg;

  typedef enum logic [2:0] {
    DSPI_NONE      = 3'd0,
    DSPI_SEND_CMD  = 3'd1,
    DSPI_SEND_DATA = 3'd2
  } dspi_cmd_e;

  typedef enum logic [2:0] {
    SPI_OFF,
    SPI_IDLE,
    SPI_LEAD,
    SPI_SETUP,
    SPI_HIGH,
    SPI_LOW
  } spi_state_e;

  typedef enum logic [2:0] {
    DISP_RST_LOW,
    DISP_RST_HIGH,
    DISP_INIT,
    DISP_FRAME_HDR,
    DISP_FETCH,
    DISP_WAIT_DATA,
    DISP_SEND
  } disp_state_e;

  localparam int NUM_COLUMNS = 128;
  localparam int NUM_PAGES   = 8;
  localparam int INIT_LEN    = 8;
  localparam int HDR_LEN     = 6;

  localparam logic [6:0] COL_LAST  = 7'(NUM_COLUMNS - 1);
  localparam logic [2:0] PAGE_LAST = 3'(NUM_PAGES - 1);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);
  localparam logic [2:0] HDR_LAST  = 3'(HDR_LEN - 1);

  // Display off, charge pump on, horizontal addressing, segment/COM remap, display on.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'hAE;
      3'd1:    init_cmd = 8'h8D;
      3'd2:    init_cmd = 8'h14;
      3'd3:    init_cmd = 8'h20;
      3'd4:    init_cmd = 8'h00;
      3'd5:    init_cmd = 8'hA1;
      3'd6:    init_cmd = 8'hC8;
      default: init_cmd = 8'hAF;
    endcase
  endfunction

  // Column window 0..127, page window 0..7.
  function automatic logic [7:0] hdr_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_cmd = 8'h21;
      3'd1:    hdr_cmd = 8'h00;
      3'd2:    hdr_cmd = 8'h7F;
      3'd3:    hdr_cmd = 8'h22;
      3'd4:    hdr_cmd = 8'h00;
      default: hdr_cmd = 8'h07;
    endcase
  endfunction

endpackage

// File: rtl/display_if.sv
// Pixel-source request bus and panel SPI pins of the display driver.
interface display_if;
  logic       d_read;
  logic [2:0] d_page_idx;
  logic [6:0] d_column_idx;
  logic [7:0] d_data;
  logic       d_data_ready;
  logic       spi_din;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_dc;
  logic       spi_rst;

  modport master (
    output d_read, d_page_idx, d_column_idx,
    output spi_din, spi_clk, spi_cs, spi_dc, spi_rst,
    input  d_data, d_data_ready
  );

  modport slave (
    input  d_read, d_page_idx, d_column_idx,
    input  spi_din, spi_clk, spi_cs, spi_dc, spi_rst,
    output d_data, d_data_ready
  );
endinterface

// File: rtl/display_spi.sv
// Mode-0 byte serializer for the panel. dc is driven one cycle ahead of cs,
// data shifts MSB first on the falling edge of spi_clk.
module display_spi
  import display_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: a command other than DSPI_NONE is taken in any cycle with
  // dspi_ready=1; ready then stays low until the byte's cs has risen again.
  input  dspi_cmd_e  dspi_cmd,
  input  logic [7:0] dspi_byte,
  output logic       dspi_ready,
  output logic       spi_din,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_dc,
  output spi_state_e dbg_state
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  spi_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        cs_q, cs_d, sclk_q, sclk_d, din_q, din_d, dc_q, dc_d;

  assign dspi_ready = (state_q == SPI_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    dc_d    = dc_q;
    case (state_q)
      SPI_OFF: state_d = SPI_IDLE;
      SPI_IDLE: begin
        if (dspi_cmd != DSPI_NONE) begin
          state_d = SPI_LEAD;
          shift_d = dspi_byte;
          dc_d    = (dspi_cmd == DSPI_SEND_DATA);
        end
      end
      SPI_LEAD: begin
        state_d = SPI_SETUP;
        cs_d    = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        din_d   = shift_q[7];
      end
      SPI_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SPI_HIGH;
          sclk_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SPI_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SPI_LOW;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          shift_d = {shift_q[6:0], 1'b0};
          din_d   = shift_q[6];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SPI_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = SPI_IDLE;
            cs_d    = 1'b1;
          end else begin
            state_d = SPI_HIGH;
            sclk_d  = 1'b1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = SPI_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SPI_OFF;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      dc_q    <= dc_d;
    end
  end

  assign spi_cs    = cs_q;
  assign spi_clk   = sclk_q;
  assign spi_din   = din_q;
  assign spi_dc    = dc_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/display.sv
// SSD1306 128x64 driver: panel reset, one-time init, then endless frames of
// header commands followed by 1024 pixel bytes fetched page-major.
module display
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  display_if.master   bus,
  output disp_state_e dbg_state,
  output spi_state_e  dbg_spi_state
);

  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

  disp_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  page_q, page_d;
  logic [6:0]  column_q, column_d;
  logic [7:0]  pix_q, pix_d;
  logic        spi_rst_q, spi_rst_d;
  logic        d_read_q, d_read_d;

  dspi_cmd_e   dspi_cmd;
  logic [7:0]  dspi_byte;
  logic        dspi_ready;
  logic        spi_din, spi_clk, spi_cs, spi_dc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    page_d    = page_q;
    column_d  = column_q;
    pix_d     = pix_q;
    spi_rst_d = spi_rst_q;
    d_read_d  = 1'b0;
    dspi_cmd  = DSPI_NONE;
    dspi_byte = 8'h00;
    case (state_q)
      DISP_RST_LOW: begin
        if (cnt_q == RST_LAST) begin
          state_d   = DISP_RST_HIGH;
          cnt_d     = '0;
          spi_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DISP_RST_HIGH: begin
        if (cnt_q == RST_LAST) begin
          state_d = DISP_INIT;
          step_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DISP_INIT: begin
        if (dspi_ready) begin
          dspi_cmd  = DSPI_SEND_CMD;
          dspi_byte = init_cmd(step_q);
          step_d    = step_q + 3'd1;
          if (step_q == INIT_LAST) begin
            state_d = DISP_FRAME_HDR;
            step_d  = '0;
          end
        end
      end
      DISP_FRAME_HDR: begin
        if (dspi_ready) begin
          dspi_cmd  = DSPI_SEND_CMD;
          dspi_byte = hdr_cmd(step_q);
          step_d    = step_q + 3'd1;
          if (step_q == HDR_LAST) begin
            state_d = DISP_FETCH;
            step_d  = '0;
          end
        end
      end
      DISP_FETCH: begin
        d_read_d = 1'b1;
        state_d  = DISP_WAIT_DATA;
      end
      DISP_WAIT_DATA: begin
        if (bus.d_data_ready) begin
          pix_d   = bus.d_data;
          state_d = DISP_SEND;
        end
      end
      DISP_SEND: begin
        // Indices advance only once the byte is accepted, so the next fetch
        // always presents the following pixel position.
        if (dspi_ready) begin
          dspi_cmd  = DSPI_SEND_DATA;
          dspi_byte = pix_q;
          state_d   = DISP_FETCH;
          if (column_q == COL_LAST) begin
            column_d = '0;
            if (page_q == PAGE_LAST) begin
              page_d  = '0;
              state_d = DISP_FRAME_HDR;
            end else begin
              page_d = page_q + 3'd1;
            end
          end else begin
            column_d = column_q + 7'd1;
          end
        end
      end
      default: state_d = DISP_RST_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DISP_RST_LOW;
      cnt_q     <= '0;
      step_q    <= '0;
      page_q    <= '0;
      column_q  <= '0;
      pix_q     <= '0;
      spi_rst_q <= 1'b0;
      d_read_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      page_q    <= page_d;
      column_q  <= column_d;
      pix_q     <= pix_d;
      spi_rst_q <= spi_rst_d;
      d_read_q  <= d_read_d;
    end
  end

  display_spi #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk        (clk),
    .rst_n      (rst_n),
    .dspi_cmd   (dspi_cmd),
    .dspi_byte  (dspi_byte),
    .dspi_ready (dspi_ready),
    .spi_din    (spi_din),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .dbg_state  (dbg_spi_state)
  );

  assign bus.d_read       = d_read_q;
  assign bus.d_page_idx   = page_q;
  assign bus.d_column_idx = column_q;
  assign bus.spi_rst      = spi_rst_q;
  assign bus.spi_din      = spi_din;
  assign bus.spi_clk      = spi_clk;
  assign bus.spi_cs       = spi_cs;
  assign bus.spi_dc       = spi_dc;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_display.sv
// Bench for the display driver: pixel-source model, SPI decoder with timing
// checks, and an expected-byte scoreboard.
module tb_display;
  import display_pkg::*;

  localparam int CLK_DIV      = 2;
  localparam int RESET_CYCLES = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  disp_state_e dbg_state;
  spi_state_e  dbg_spi_state;

  display_if bus ();

  display #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RESET_CYCLES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .dbg_state     (dbg_state),
    .dbg_spi_state (dbg_spi_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  int         nbytes = 0;
  int         ndata = 0;
  logic [7:0] last_byte = 8'h00;

  int resp_delay = 3;
  bit stray_en   = 1'b0;
  bit a5_mode    = 1'b0;

  logic [7:0] init_tbl [0:7] = '{8'hAE, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF};
  logic [7:0] hdr_tbl  [0:5] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_hdr();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, hdr_tbl[i]});
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, init_tbl[i]});
    push_hdr();
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n = 0;
    while (nbytes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (nbytes >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- SPI decoder / timing monitor ----------------
  bit         in_byte = 1'b0;
  logic       prev_sclk = 1'b0, prev_din = 1'b0, prev_dc = 1'b0, dc_at = 1'b0;
  int         run_hi = 0, run_lo = 0, lead = 0, nrise = 0;
  logic [7:0] shreg = 8'h00;
  logic [8:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_byte   = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (!bus.spi_cs) begin
        if (!in_byte) begin
          in_byte = 1'b1;
          check("dc_setup_before_cs", bus.spi_dc, prev_dc);
          dc_at = bus.spi_dc;
          lead = 0; run_lo = 0; run_hi = 0; nrise = 0; shreg = 8'h00;
        end
        check("dc_stable_cs_low", bus.spi_dc, dc_at);
        if (bus.spi_clk) begin
          if (!prev_sclk) begin
            if (nrise == 0) check("cs_setup", (lead >= CLK_DIV) ? 32'd1 : 32'd0, 32'd1);
            else            check("low_phase", run_lo, CLK_DIV);
            shreg = {shreg[6:0], bus.spi_din};
            nrise++;
            run_hi = 0;
          end else begin
            check("din_stable_high", bus.spi_din, prev_din);
          end
          run_hi++;
        end else begin
          if (prev_sclk) begin
            check("high_phase", run_hi, CLK_DIV);
            run_lo = 0;
          end
          run_lo++;
          if (nrise == 0) lead++;
        end
      end else if (in_byte) begin
        in_byte = 1'b0;
        check("cs_hold", (run_lo >= CLK_DIV) ? 32'd1 : 32'd0, 32'd1);
        check("bits_per_byte", nrise, 8);
        if (exp_q.size() == 0) begin
          check("sb_queue_size", exp_q.size(), 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_byte", {dc_at, shreg}, exp_e);
        end
        last_byte = shreg;
        nbytes++;
        if (dc_at) ndata++;
      end
      prev_sclk = bus.spi_clk;
      prev_din  = bus.spi_din;
    end
    prev_dc = bus.spi_dc;
  end

  // ---------------- pixel source model ----------------
  initial begin : model
    int         wait_cnt;
    bit         pending;
    bit         prev_dread;
    logic [2:0] pg, exp_pg;
    logic [6:0] col, exp_col;
    logic [7:0] d;
    wait_cnt = 0; pending = 1'b0; prev_dread = 1'b0;
    pg = '0; col = '0; exp_pg = '0; exp_col = '0;
    bus.d_data = 8'h00;
    bus.d_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.d_data_ready = 1'b0;
      if (!rst_n) begin
        pending = 1'b0; prev_dread = 1'b0; exp_pg = '0; exp_col = '0;
      end else begin
        if (pending) begin
          if (wait_cnt == 100) check("cs_idle_while_waiting", bus.spi_cs, 1);
          if (wait_cnt <= 0) begin
            check("page_stable", bus.d_page_idx, pg);
            check("col_stable", bus.d_column_idx, col);
            d = a5_mode ? 8'hA5 : {1'b0, pg, col[6:3]};
            bus.d_data = d;
            bus.d_data_ready = 1'b1;
            exp_q.push_back({1'b1, d});
            if (pg == 3'd7 && col == 7'd127) push_hdr();
            pending = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        if (bus.d_read) begin
          check("d_read_pulse_width", prev_dread, 0);
          check("d_read_while_pending", pending, 0);
          check("page_order", bus.d_page_idx, exp_pg);
          check("col_order", bus.d_column_idx, exp_col);
          pg = bus.d_page_idx;
          col = bus.d_column_idx;
          {exp_pg, exp_col} = {exp_pg, exp_col} + 10'd1;
          pending = 1'b1;
          wait_cnt = resp_delay - 1;
        end
        if (stray_en && !pending && !bus.d_data_ready && $urandom_range(0, 3) == 0) begin
          bus.d_data = 8'hEE;
          bus.d_data_ready = 1'b1;
        end
        prev_dread = bus.d_read;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_cs", bus.spi_cs, 1);
    check("rst_spi_clk", bus.spi_clk, 0);
    check("rst_spi_din", bus.spi_din, 0);
    check("rst_spi_dc", bus.spi_dc, 0);
    check("rst_spi_rst", bus.spi_rst, 0);
    check("rst_d_read", bus.d_read, 0);
    check("rst_page", bus.d_page_idx, 0);
    check("rst_column", bus.d_column_idx, 0);
    check("rst_dspi_ready", dut.dspi_ready, 0);

    @(negedge clk);
    exp_q.delete();
    push_init();
    rst_n = 1'b1;

    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.spi_rst == 1'b0 && n < 1000);
    check("spi_rst_low_cycles", n, RESET_CYCLES);

    // RST_HIGH lasts RESET_CYCLES, then one cycle to issue the command and one for dc lead.
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.spi_cs == 1'b1 && n < 1000);
    check("spi_rst_high_to_cs_low", n, RESET_CYCLES + 2);
    check("first_byte_dc", bus.spi_dc, 0);

    wait_bytes(14 + 1024 + 6, 45000, "frame1_timeout");
    check("frame1_data_bytes", ndata, 1024);

    resp_delay = 500;
    stray_en   = 1'b1;
    wait_bytes(nbytes + 4, 4000, "slow_source_timeout");

    stray_en   = 1'b0;
    a5_mode    = 1'b1;
    resp_delay = 3;
    wait_bytes(nbytes + 3, 3000, "a5_timeout");
    check("a5_pattern", last_byte, 8'hA5);

    n = 0;
    while (!(bus.spi_cs == 1'b0 && bus.spi_clk == 1'b1) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("mid_byte_found", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_spi_cs", bus.spi_cs, 1);
    check("abort_spi_rst", bus.spi_rst, 0);
    check("abort_d_read", bus.d_read, 0);
    check("abort_spi_clk", bus.spi_clk, 0);
    check("abort_state", dbg_state, DISP_RST_LOW);
    exp_q.delete();
    a5_mode = 1'b0;
    base = nbytes;
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    wait_bytes(base + 15, 3000, "restart_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
